// File: rtl/mm_result_reader.sv
// Result RAM reader: fills an 8x8 matrix column-major, drains it row-major over valid/ready.
// Optional build macro MM_RDR_CHECKSUM_EN adds a running checksum output of the stored words.
//
// state   | meaning
// S_FILL  | accepting writes at wr_count
// S_FULL  | matrix complete, waiting for start
// S_DRAIN | streaming elements row-major
// S_DONE  | matrix drained; next write starts a new matrix
module mm_result_reader #(
    parameter int DATA_W = 19,
    parameter int DIM    = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic              write_enable,
    input  logic              start,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [2:0]        rd_row,
    output logic [2:0]        rd_col,
    output logic              full,
    output logic              done,
    output logic              overflow,
`ifdef MM_RDR_CHECKSUM_EN
    output logic signed [DATA_W+5:0] checksum,
`endif
    output logic [ADDR_W:0]   wr_count
);
    localparam int NWORDS = DIM * DIM;
    localparam int IW     = ADDR_W / 2;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(NWORDS);
    localparam logic [2:0]      LAST_IDX = 3'(DIM - 1);

    typedef enum logic [1:0] {S_FILL, S_FULL, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [2:0]          rd_row_q, rd_row_d;
    logic [2:0]          rd_col_q, rd_col_d;
    logic                full_q, full_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic [ADDR_W:0]     wr_count_q, wr_count_d;
    logic [ADDR_W:0]     fetch_cnt_q, fetch_cnt_d;

    logic [DATA_W-1:0]   mem_q [NWORDS];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [ADDR_W-1:0]   rd_addr;

`ifdef MM_RDR_CHECKSUM_EN
    localparam int CS_W = DATA_W + 6;
    logic signed [CS_W-1:0] cs_q, cs_d;
    logic signed [CS_W-1:0] in_sx;
    assign in_sx = {{(CS_W - DATA_W){in[DATA_W-1]}}, in};
`endif

    // fetch_cnt walks row-major; storage is column-major, so swap the halves for the address
    assign rd_addr = {fetch_cnt_q[IW-1:0], fetch_cnt_q[ADDR_W-1:IW]};

    always_comb begin
        state_d     = state_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        rd_row_d    = rd_row_q;
        rd_col_d    = rd_col_q;
        full_d      = full_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
        wr_count_d  = wr_count_q;
        fetch_cnt_d = fetch_cnt_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_count_q[ADDR_W-1:0];
`ifdef MM_RDR_CHECKSUM_EN
        cs_d        = cs_q;
`endif
        case (state_q)
            S_FILL: begin
                if (write_enable) begin
                    mem_we     = 1'b1;
                    wr_count_d = wr_count_q + 1'b1;
`ifdef MM_RDR_CHECKSUM_EN
                    cs_d       = cs_q + in_sx;
`endif
                    if (wr_count_d == FULL_CNT) begin
                        full_d  = 1'b1;
                        state_d = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (write_enable) overflow_d = 1'b1;
                if (start) begin
                    state_d     = S_DRAIN;
                    fetch_cnt_d = '0;
                    rd_row_d    = '0;
                    rd_col_d    = '0;
                end
            end
            S_DRAIN: begin
                if (write_enable) overflow_d = 1'b1;
                if (rd_valid_q && rd_ready && rd_row_q == LAST_IDX && rd_col_q == LAST_IDX) begin
                    rd_valid_d = 1'b0;
                    full_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end else if ((!rd_valid_q || rd_ready) && fetch_cnt_q != FULL_CNT) begin
                    rd_data_d   = mem_q[rd_addr];
                    rd_row_d    = fetch_cnt_q[ADDR_W-1:IW];
                    rd_col_d    = fetch_cnt_q[IW-1:0];
                    rd_valid_d  = 1'b1;
                    fetch_cnt_d = fetch_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (write_enable) begin
                    mem_we     = 1'b1;
                    mem_waddr  = '0;
                    wr_count_d = (ADDR_W + 1)'(1);
                    done_d     = 1'b0;
                    state_d    = S_FILL;
`ifdef MM_RDR_CHECKSUM_EN
                    cs_d       = in_sx;
`endif
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FILL;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            wr_count_q  <= '0;
            fetch_cnt_q <= '0;
`ifdef MM_RDR_CHECKSUM_EN
            cs_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            full_q      <= full_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            wr_count_q  <= wr_count_d;
            fetch_cnt_q <= fetch_cnt_d;
`ifdef MM_RDR_CHECKSUM_EN
            cs_q        <= cs_d;
`endif
        end
    end

    // storage has no reset; contents are only meaningful once written
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= in;
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_row   = rd_row_q;
    assign rd_col   = rd_col_q;
    assign full     = full_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign wr_count = wr_count_q;
`ifdef MM_RDR_CHECKSUM_EN
    assign checksum = cs_q;
`endif

endmodule

// File: tb/tb_mm_result_reader.sv
// Randomized bench for mm_result_reader against a matrix-level model held in the bench.
module tb_mm_result_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] in = '0;
    logic        write_enable = 1'b0;
    logic        start = 1'b0;
    logic [18:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [2:0]  rd_row, rd_col;
    logic        full, done, overflow;
    logic [6:0]  wr_count;
`ifdef MM_RDR_CHECKSUM_EN
    logic signed [24:0] checksum;
`endif

    mm_result_reader dut (
        .clk(clk), .reset(reset), .in(in), .write_enable(write_enable), .start(start),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_row(rd_row), .rd_col(rd_col), .full(full), .done(done), .overflow(overflow),
`ifdef MM_RDR_CHECKSUM_EN
        .checksum(checksum),
`endif
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model: matrix as written, expected sticky flag, running signed sum
    logic [18:0] model_c [8][8];
    bit          model_ovf = 1'b0;
    int          model_sum = 0;
    int          xfer_n = 0;
    logic [18:0] got_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // compare process: every transfer against the model, and held data while stalled
    bit          hold = 1'b0;
    logic [18:0] h_data;
    logic [2:0]  h_row, h_col;
    always @(negedge clk) begin
        if (!reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", {31'b0, rd_valid}, 32'd1);
                chk("hold_data", {13'b0, rd_data}, {13'b0, h_data});
                chk("hold_rowcol", {26'b0, rd_row, rd_col}, {26'b0, h_row, h_col});
            end
            if (rd_valid && rd_ready) begin
                if (xfer_n >= 64) begin
                    chk("extra_xfer", 32'(xfer_n), 32'd63);
                end else begin
                    chk("xfer_row", {29'b0, rd_row}, 32'(xfer_n / 8));
                    chk("xfer_col", {29'b0, rd_col}, 32'(xfer_n % 8));
                    chk("xfer_data", {13'b0, rd_data}, {13'b0, model_c[xfer_n / 8][xfer_n % 8]});
                    got_q.push_back(rd_data);
                    xfer_n++;
                end
            end
            hold   = rd_valid && !rd_ready;
            h_data = rd_data;
            h_row  = rd_row;
            h_col  = rd_col;
        end
    end

    function automatic logic [18:0] word_val(input int mode, input int k);
        logic [18:0] v;
        case (mode)
            0: v = 19'(k);
            1: v = 19'(100 + k);
            default: begin
                v = 19'($urandom);
                if (k == 0)  v = 19'h40000;
                if (k == 63) v = 19'h3FFFF;
            end
        endcase
        return v;
    endfunction

    function automatic bit ready_pat(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 4 == 0) || (c % 4 == 3);
        return ($urandom % 4) != 0;
    endfunction

    task automatic fill(input int mode, input int from, input int to);
        logic [18:0] v;
        for (int k = from; k <= to; k++) begin
            repeat ($urandom % 3) begin
                write_enable = 1'b0;
                start = 1'($urandom % 2);
                @(posedge clk); #1;
            end
            v = word_val(mode, k);
            write_enable = 1'b1;
            in = v;
            start = 1'($urandom % 2);
            if (k == 0) model_sum = 0;
            model_c[k % 8][k / 8] = v;
            model_sum += int'($signed(v));
            @(posedge clk); #1;
            write_enable = 1'b0;
            start = 1'b0;
            @(negedge clk);
            chk("wr_count", {25'b0, wr_count}, 32'(k + 1));
            chk("full_flag", {31'b0, full}, (k == 63) ? 32'd1 : 32'd0);
            chk("done_low", {31'b0, done}, 32'd0);
            chk("no_valid_fill", {31'b0, rd_valid}, 32'd0);
        end
`ifdef MM_RDR_CHECKSUM_EN
        if (to == 63) chk("checksum_model", {7'b0, checksum}, {7'b0, 25'(model_sum)});
`endif
    endtask

    task automatic drain(input int mode, input int target, input bit wr_too);
        int c;
        xfer_n = 0;
        got_q.delete();
        rd_ready = ready_pat(mode, 0);
        @(posedge clk); #1;
        start = 1'b1;
        write_enable = wr_too;
        in = 19'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        write_enable = 1'b0;
        if (wr_too) model_ovf = 1'b1;
        @(negedge clk);
        chk("latency_c1", {31'b0, rd_valid}, 32'd0);
        @(negedge clk);
        chk("latency_c2", {31'b0, rd_valid}, 32'd1);
        c = 0;
        while (xfer_n < target && c < 2000) begin
            @(posedge clk); #1;
            if (xfer_n >= target) break;
            c++;
            rd_ready = ready_pat(mode, c);
        end
        if (c >= 2000) chk("drain_timeout", 32'(xfer_n), 32'(target));
        if (target == 64) begin
            @(negedge clk);
            chk("drain_done", {31'b0, done}, 32'd1);
            chk("drain_full", {31'b0, full}, 32'd0);
            chk("drain_valid", {31'b0, rd_valid}, 32'd0);
            chk("drain_count", 32'(xfer_n), 32'd64);
            chk("overflow", {31'b0, overflow}, {31'b0, model_ovf});
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_data"}, {13'b0, rd_data}, 32'd0);
        chk({nm, "_valid"}, {31'b0, rd_valid}, 32'd0);
        chk({nm, "_rowcol"}, {26'b0, rd_row, rd_col}, 32'd0);
        chk({nm, "_full"}, {31'b0, full}, 32'd0);
        chk({nm, "_done"}, {31'b0, done}, 32'd0);
        chk({nm, "_ovf"}, {31'b0, overflow}, 32'd0);
        chk({nm, "_wrcnt"}, {25'b0, wr_count}, 32'd0);
`ifdef MM_RDR_CHECKSUM_EN
        chk({nm, "_cs"}, {7'b0, checksum}, 32'd0);
`endif
    endtask

    initial begin
        #2 reset = 1'b0;
        #1 chk_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // ramp fill and full-rate drain
        fill(0, 0, 63);
        drain(0, 64, 1'b0);
        chk("ramp_first", {13'b0, got_q[0]}, 32'd0);
        chk("ramp_second", {13'b0, got_q[1]}, 32'd8);
        chk("ramp_ninth", {13'b0, got_q[8]}, 32'd1);
        chk("ramp_last", {13'b0, got_q[63]}, 32'd63);
`ifdef MM_RDR_CHECKSUM_EN
        chk("checksum_ramp", {7'b0, checksum}, 32'd2016);
`endif
        // start in DONE does nothing
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("done_start_valid", {31'b0, rd_valid}, 32'd0);
            chk("done_hold", {31'b0, done}, 32'd1);
        end

        // back-to-back matrix with 1,0,0,1 backpressure
        fill(1, 0, 63);
        drain(1, 64, 1'b0);
        chk("b2b_first", {13'b0, got_q[0]}, 32'd100);
        chk("b2b_second", {13'b0, got_q[1]}, 32'd108);
`ifdef MM_RDR_CHECKSUM_EN
        chk("checksum_b2b", {7'b0, checksum}, 32'd8416);
`endif

        // protocol errors and signed extremes, random ready
        fill(2, 0, 9);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("early_start_valid", {31'b0, rd_valid}, 32'd0);
        end
        chk("early_start_wrcnt", {25'b0, wr_count}, 32'd10);
        fill(2, 10, 63);
        @(posedge clk); #1 write_enable = 1'b1; in = 19'h1234;
        @(posedge clk); #1 write_enable = 1'b0;
        model_ovf = 1'b1;
        @(negedge clk);
        chk("full_wr_ovf", {31'b0, overflow}, 32'd1);
        chk("full_wr_cnt", {25'b0, wr_count}, 32'd64);
        chk("full_wr_full", {31'b0, full}, 32'd1);
        drain(2, 64, 1'b1);
        chk("extreme_min", {13'b0, got_q[0]}, 32'h40000);
        chk("extreme_max", {13'b0, got_q[63]}, 32'h3FFFF);

        // reset in the middle of a drain, then a clean ramp
        fill(2, 0, 63);
        drain(2, 20, 1'b0);
        reset = 1'b0;
        #1 chk_zero("abort");
        model_ovf = 1'b0;
        xfer_n = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        fill(0, 0, 63);
        drain(0, 64, 1'b0);
        chk("rst_ramp_second", {13'b0, got_q[1]}, 32'd8);
        chk("rst_ramp_last", {13'b0, got_q[63]}, 32'd63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
